// File: rtl/cpu_run_ctrl.sv
// Run/debug controller for the RV32 single-cycle core.
// Sequences idle, free-run, single-step and halt; owns core reset/enable.
module cpu_run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             resume,
  input  logic             halt_req,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             Ecall,
  input  logic             Ebreak,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             halted,
  output logic             done,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_STEP,
    S_HALTED,
    S_DONE
  } state_t;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_ECALL = 3'd1;
  localparam logic [2:0] C_EBRK  = 3'd2;
  localparam logic [2:0] C_HREQ  = 3'd3;
  localparam logic [2:0] C_STEP  = 3'd4;
  localparam logic [2:0] C_TOUT  = 3'd5;

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;

  // Count saturates so a long unlimited run never wraps to a small value.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign limit_hit = (cycle_limit != '0) && (cnt_inc == cycle_limit);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start || step) begin
          state_d = start ? S_RUN : S_STEP;
          cause_d = C_NONE;
          cnt_d   = '0;
        end
      end
      S_RST: begin
        state_d = S_RUN;
        cause_d = C_NONE;
        cnt_d   = '0;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (Ecall) begin
          state_d = S_DONE;
          cause_d = C_ECALL;
        end else if (Ebreak) begin
          state_d = S_HALTED;
          cause_d = C_EBRK;
        end else if (limit_hit) begin
          state_d = S_DONE;
          cause_d = C_TOUT;
        end else if (halt_req) begin
          state_d = S_HALTED;
          cause_d = C_HREQ;
        end
      end
      S_STEP: begin
        cnt_d = cnt_inc;
        if (Ecall) begin
          state_d = S_DONE;
          cause_d = C_ECALL;
        end else if (Ebreak) begin
          state_d = S_HALTED;
          cause_d = C_EBRK;
        end else if (limit_hit) begin
          state_d = S_DONE;
          cause_d = C_TOUT;
        end else begin
          state_d = S_HALTED;
          cause_d = C_STEP;
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_RST;
          cause_d = C_NONE;
          cnt_d   = '0;
        end else if (resume) begin
          state_d = S_RUN;
          cause_d = C_NONE;
        end else if (step) begin
          state_d = S_STEP;
          cause_d = C_NONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RST;
          cause_d = C_NONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cause_d = C_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_rst   = (state_q == S_IDLE) || (state_q == S_RST);
  assign core_en    = (state_q == S_RUN) || (state_q == S_STEP);
  assign busy       = core_en;
  assign halted     = (state_q == S_HALTED);
  assign done       = (state_q == S_DONE);
  assign halt_cause = cause_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl.
// Expected status snapshots are queued with each stimulus cycle.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, step, resume, halt_req;
  logic [31:0] cycle_limit;
  logic        Ecall, Ebreak;
  logic        core_rst, core_en, busy, halted, done;
  logic [2:0]  halt_cause;
  logic [31:0] cycle_cnt;

  cpu_run_ctrl #(.CNT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .step(step),
    .resume(resume),
    .halt_req(halt_req),
    .cycle_limit(cycle_limit),
    .Ecall(Ecall),
    .Ebreak(Ebreak),
    .core_rst(core_rst),
    .core_en(core_en),
    .busy(busy),
    .halted(halted),
    .done(done),
    .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int en_cnt = 0;

  string       tag_q[$];
  logic [39:0] exp_q[$];

  always @(posedge clk) en_cnt += int'(core_en);

  function automatic logic [39:0] st(
    input bit r, input bit e, input bit b, input bit h, input bit d,
    input int c, input int n
  );
    return {r, e, b, h, d, 3'(c), 32'(n)};
  endfunction

  function automatic logic [39:0] obs();
    return {core_rst, core_en, busy, halted, done, halt_cause, cycle_cnt};
  endfunction

  task automatic check(input string tag, input logic [39:0] got,
                       input logic [39:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic clr();
    start = 0; step = 0; resume = 0;
    halt_req = 0; Ecall = 0; Ebreak = 0;
  endtask

  // Queue the expected post-edge status, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [39:0] want);
    tag_q.push_back(tag);
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), obs(), exp_q.pop_front());
  endtask

  localparam logic [39:0] IDLE = 40'h80_0000_0000;
  localparam logic [39:0] RSTS = 40'h80_0000_0000;

  initial begin
    reset = 0;
    cycle_limit = 0;
    clr();
    #1;
    check("reset_state", obs(), IDLE);
    @(posedge clk); #1;
    reset = 1;
    cyc("idle_hold", IDLE);

    // Free run ended by ECALL on the 10th enabled cycle.
    start = 1;
    en_cnt = 0;
    cyc("t1_start", st(0,1,1,0,0,0,0));
    clr();
    for (int i = 1; i <= 9; i++) cyc($sformatf("t1_run%0d", i), st(0,1,1,0,0,0,i));
    Ecall = 1;
    cyc("t1_ecall", st(0,0,0,0,1,1,10));
    clr();
    check("t1_en_cycles", 40'(en_cnt), 40'd10);

    // Cycle limit timeout, DONE ignores everything but start.
    cycle_limit = 5;
    start = 1;
    cyc("t2_rst", RSTS);
    clr();
    en_cnt = 0;
    cyc("t2_run0", st(0,1,1,0,0,0,0));
    for (int i = 1; i <= 4; i++) cyc($sformatf("t2_run%0d", i), st(0,1,1,0,0,0,i));
    cyc("t2_tout", st(0,0,0,0,1,5,5));
    check("t2_en_cycles", 40'(en_cnt), 40'd5);
    step = 1; resume = 1; halt_req = 1;
    cyc("t2_done_hold", st(0,0,0,0,1,5,5));
    clr();
    start = 1;
    cyc("t2_restart_rst", RSTS);
    clr();
    cycle_limit = 0;
    cyc("t3_run0", st(0,1,1,0,0,0,0));

    // EBREAK halt, two steps, resume.
    cyc("t3_run1", st(0,1,1,0,0,0,1));
    cyc("t3_run2", st(0,1,1,0,0,0,2));
    Ebreak = 1;
    cyc("t3_ebreak", st(0,0,0,1,0,2,3));
    clr();
    cyc("t3_halt_hold", st(0,0,0,1,0,2,3));
    en_cnt = 0;
    step = 1;
    cyc("t3_step1", st(0,1,1,0,0,0,3));
    clr();
    cyc("t3_step1_done", st(0,0,0,1,0,4,4));
    step = 1;
    cyc("t3_step2", st(0,1,1,0,0,0,4));
    clr();
    cyc("t3_step2_done", st(0,0,0,1,0,4,5));
    check("t3_en_cycles", 40'(en_cnt), 40'd2);
    resume = 1;
    cyc("t3_resume", st(0,1,1,0,0,0,5));
    clr();

    // Host halt request, halt_req held across resume, EBREAK priority.
    halt_req = 1;
    cyc("t4_hreq", st(0,0,0,1,0,3,6));
    resume = 1;
    cyc("t4_resume_hreq", st(0,1,1,0,0,0,6));
    resume = 0;
    cyc("t4_rehalt", st(0,0,0,1,0,3,7));
    clr();
    resume = 1;
    cyc("t4_resume2", st(0,1,1,0,0,0,7));
    clr();
    halt_req = 1; Ebreak = 1;
    cyc("t4_ebrk_prio", st(0,0,0,1,0,2,8));
    clr();
    start = 1; resume = 1; step = 1;
    cyc("t4_start_prio", RSTS);
    clr();
    cyc("t4_run0", st(0,1,1,0,0,0,0));
    Ecall = 1; Ebreak = 1;
    cyc("t4_ecall_prio", st(0,0,0,0,1,1,1));
    clr();

    // Asynchronous reset in the middle of a run.
    start = 1;
    cyc("t6_rst", RSTS);
    clr();
    cyc("t6_run0", st(0,1,1,0,0,0,0));
    cyc("t6_run1", st(0,1,1,0,0,0,1));
    #3;
    reset = 0;
    #1;
    check("t6_async_reset", obs(), IDLE);
    @(posedge clk); #1;
    reset = 1;

    // Single step from IDLE with ECALL decoded.
    en_cnt = 0;
    step = 1;
    cyc("t5_step_idle", st(0,1,1,0,0,0,0));
    clr();
    Ecall = 1;
    cyc("t5_step_ecall", st(0,0,0,0,1,1,1));
    clr();
    check("t5_en_cycles", 40'(en_cnt), 40'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/debug controller for the RV32 single-cycle core. Owns the core's reset and clock-enable, and sequences it through idle, free-run, single-step and halt. It halts on ECALL/EBREAK decode, a host halt request or a cycle limit, and reports the halt cause and the enabled-cycle count. Sits in `top` between the host/bench controls and the core. The core qualifies PC, register-file and data-memory writes with `core_en`.

## Interface
- `CNT_W`, 32: width of `cycle_cnt` and `cycle_limit`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = in reset.
- `start`  in  1  single-cycle pulse; (re)start the program from PC reset.
- `step`  in  1  single-cycle pulse; execute exactly one instruction.
- `resume`  in  1  single-cycle pulse; continue free-run from HALTED.
- `halt_req`  in  1  level; stop at the next instruction boundary.
- `cycle_limit`  in  CNT_W  maximum enabled cycles per run; 0 = unlimited.
- `Ecall`  in  1  core decode of the current instruction, sampled only while `core_en`=1.
- `Ebreak`  in  1  core decode of the current instruction, sampled only while `core_en`=1.
- `core_rst`  out  1  active-high reset to the core.
- `core_en`  out  1  core commit enable.
- `busy`  out  1  state is RUN or STEP.
- `halted`  out  1  state is HALTED (resumable).
- `done`  out  1  state is DONE (terminal until `start`).
- `halt_cause`  out  3  0 none, 1 ecall, 2 ebreak, 3 halt_req, 4 step, 5 timeout.
- `cycle_cnt`  out  CNT_W  enabled cycles since the last start.

## Operation
- States: IDLE, RST, RUN, STEP, HALTED, DONE. All outputs are registered or decoded from state only.
- `core_rst`=1 in IDLE and RST. `core_en`=1 in RUN and STEP.
- IDLE:
  - `start` -> RUN.
  - `step` -> STEP.
  - On either, clear `cycle_cnt` and set `halt_cause`=0.
- RST: one cycle, then RUN. Clears `cycle_cnt` and `halt_cause`.
- RUN, evaluated every cycle in priority order:
  - `Ecall` -> DONE/1.
  - `Ebreak` -> HALTED/2.
  - Limit hit -> DONE/5.
  - `halt_req` -> HALTED/3.
  - Otherwise stay in RUN.
- STEP: exactly one enabled cycle.
  - `Ecall` -> DONE/1.
  - `Ebreak` -> HALTED/2.
  - Limit hit -> DONE/5.
  - Otherwise -> HALTED/4.
  - `halt_req` is ignored.
- HALTED, priority `start` > `resume` > `step`:
  - `start` -> RST.
  - `resume` -> RUN.
  - `step` -> STEP.
  - `halt_cause` holds until the next transition out of HALTED. It is cleared to 0 on resume or step.
  - `halt_req` held high during a resume: RUN executes one cycle, then -> HALTED/3.
- DONE: only `start` -> RST. `step`, `resume` and `halt_req` are ignored.
- In IDLE, `start` has priority over `step`. `resume` and `halt_req` are ignored in IDLE.
- `start`, `step` and `resume` are ignored in RUN and STEP.
- The instruction executing while ECALL/EBREAK is decoded commits on that edge and is counted.
- `cycle_cnt`:
  - Increments on every edge where `core_en`=1.
  - Saturates at all-ones and does not wrap.
  - Cleared on entry to RST, and on leaving IDLE via `start` or `step`.
- Limit hit: `cycle_limit`≠0 and the incremented value equals `cycle_limit`.

## Timing
- Reset assertion forces, asynchronously: IDLE, `core_rst`=1, `core_en`=0, `busy`=0, `halted`=0, `done`=0, `halt_cause`=0, `cycle_cnt`=0.
- Reset asserted mid-run aborts immediately, with no drain.
- `start` sampled at edge k in IDLE: `core_en`=1 from cycle k+1. The first instruction commits at edge k+1.
- `start` sampled at edge k in HALTED/DONE: RST during cycle k+1, `core_en`=1 from cycle k+2.
- Halt latency: event sampled at edge m (with `core_en`=1) -> `core_en`=0, `halted`/`done` and `halt_cause` valid from cycle m+1.
- Step: exactly one cycle with `core_en`=1. `cycle_cnt` increases by exactly 1.
- `cycle_cnt` on an Ecall halt equals the number of committed instructions, including the ECALL.

## Test plan
- Reset low then high; `start` at cycle 2; `Ecall` forced high on the 10th enabled cycle -> `core_en` high for exactly 10 cycles, `done`=1, `halt_cause`=1, `cycle_cnt`=10.
- `cycle_limit`=5 and no `Ecall` -> `core_en` high 5 cycles, `done`=1, `halt_cause`=5, `cycle_cnt`=5; a further `start` -> 1 RST cycle with `core_rst`=1, `cycle_cnt`=0.
- `Ebreak` at cycle 3 of a run -> `halted`=1, `halt_cause`=2; then 2× `step` -> two single `core_en` pulses, `halt_cause`=4, `cycle_cnt`=5; then `resume` -> `busy`=1.
- Hold `halt_req` high during RUN -> halt one cycle later with `halt_cause`=3; same cycle with `Ebreak` also high -> `halt_cause`=2 (priority).
- `step` from IDLE with `Ecall` high -> one enabled cycle, `done`=1, `halt_cause`=1, `cycle_cnt`=1.
- Assert reset mid-RUN -> outputs immediately at reset values (`core_rst`=1, `cycle_cnt`=0) before the next clock edge.
